// File: rtl/fft_engine_if.sv
// rtl/fft_engine_if.sv - run handshake and shared sample-memory bus of the FFT engine
interface fft_engine_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11
) ();
  logic              do_fft;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              write_enable;
  logic [DATA_W-1:0] data_out_wire;
  logic              fft_done;

  // Engine side: drives the memory bus and the done flag.
  modport master (
    input  do_fft,
    input  data_in,
    output addr,
    output write_enable,
    output data_out_wire,
    output fft_done
  );

  // Controller/memory side.
  modport slave (
    output do_fft,
    output data_in,
    input  addr,
    input  write_enable,
    input  data_out_wire,
    input  fft_done
  );
endinterface

// File: rtl/fft_engine.sv
// rtl/fft_engine.sv - in-place radix-2 DIT FFT with magnitude estimate on a single-port memory
module fft_engine #(
  parameter int N_LOG2  = 10,
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 11,
  parameter int TW_FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fft_engine_if.master bus
);

  localparam int  N      = 1 << N_LOG2;
  localparam int  HALF_N = N / 2;
  localparam int  K_W    = N_LOG2 - 1;
  localparam int  TW_W   = TW_FRAC + 2;       // holds +/-2^TW_FRAC
  localparam int  PROD_W = DATA_W + TW_W;     // full-precision product
  localparam int  ACC_W  = PROD_W + 1;        // sum of two products
  localparam int  T_W    = DATA_W + 3;        // butterfly add/sub width
  localparam int  MAG_W  = DATA_W + 2;
  localparam int  STG_W  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam real PI     = 3.14159265358979323846;
  localparam real SCALE  = 2.0 ** TW_FRAC;

  localparam logic [N_LOG2-1:0] CNT_LAST  = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] HALF_LAST = N_LOG2'(HALF_N - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_LOG2 - 1);
  localparam logic [MAG_W-1:0]  MAG_MAX   = MAG_W'((1 << (DATA_W - 1)) - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR_IM,
    BITREV,
    BFLY,
    MAG,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      we_q, we_d;
  logic [DATA_W-1:0]         dout_q, dout_d;
  logic                      done_q, done_d;
  logic [N_LOG2-1:0]         cnt_q, cnt_d;    // sample index, butterfly index or bin index
  logic [STG_W-1:0]          stg_q, stg_d;    // butterfly stage, 0-based (s-1)
  logic [3:0]                ph_q, ph_d;      // micro-step within one item
  logic signed [DATA_W-1:0]  are_q, are_d;    // also holds the swap word / magnitude real part
  logic signed [DATA_W-1:0]  aim_q, aim_d;
  logic signed [DATA_W-1:0]  bre_q, bre_d;
  logic signed [DATA_W-1:0]  bim_q, bim_d;

  // Twiddle ROM: round(2^TW_FRAC * cos/sin(2*pi*k/N)) for k in 0..N/2-1.
  logic signed [TW_W-1:0] tw_cos [HALF_N];
  logic signed [TW_W-1:0] tw_sin [HALF_N];

  for (genvar g = 0; g < HALF_N; g++) begin : g_tw
    localparam real ANG   = 2.0 * PI * g / N;
    localparam real C_R   = SCALE * $cos(ANG);
    localparam real S_R   = SCALE * $sin(ANG);
    localparam int  C_INT = $rtoi(C_R + ((C_R >= 0.0) ? 0.5 : -0.5));
    localparam int  S_INT = $rtoi(S_R + ((S_R >= 0.0) ? 0.5 : -0.5));
    assign tw_cos[g] = TW_W'(C_INT);
    assign tw_sin[g] = TW_W'(S_INT);
  end

  function automatic logic [N_LOG2-1:0] bit_rev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int b = 0; b < N_LOG2; b++) r[b] = v[N_LOG2-1-b];
    return r;
  endfunction

  logic [N_LOG2-1:0]        cnt_rev;
  logic [N_LOG2-1:0]        pos_mask, bf_pos, idx_a, idx_b;
  logic [K_W-1:0]           tw_k;
  logic signed [TW_W-1:0]   tw_c, tw_s;
  logic signed [PROD_W-1:0] p_rc, p_is, p_ic, p_rs;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [T_W-1:0]    t_re, t_im, a_re_x, a_im_x;
  logic signed [T_W-1:0]    sum_re, sum_im, dif_re, dif_im;
  logic [DATA_W-1:0]        new_are, new_aim, new_bre, new_bim;
  logic [DATA_W:0]          ext_re, ext_im, abs_re, abs_im, mag_mx, mag_mn;
  logic [MAG_W-1:0]         mag_sum;
  logic [DATA_W-1:0]        mag_val;

  // Butterfly addressing, twiddle lookup, butterfly arithmetic and magnitude estimate.
  always_comb begin
    cnt_rev  = bit_rev(cnt_q);
    pos_mask = (N_LOG2'(1) << stg_q) - N_LOG2'(1);
    bf_pos   = cnt_q & pos_mask;
    idx_a    = (((cnt_q >> stg_q) << 1) << stg_q) | bf_pos;
    idx_b    = idx_a | (N_LOG2'(1) << stg_q);
    tw_k     = K_W'(bf_pos << (N_LOG2 - 1 - int'(stg_q)));
    tw_c     = tw_cos[tw_k];
    tw_s     = tw_sin[tw_k];

    // W*b with W = c - j*s: re = br*c + bi*s, im = bi*c - br*s
    p_rc   = bre_q * tw_c;
    p_is   = bim_q * tw_s;
    p_ic   = bim_q * tw_c;
    p_rs   = bre_q * tw_s;
    acc_re = ACC_W'(p_rc) + ACC_W'(p_is);
    acc_im = ACC_W'(p_ic) - ACC_W'(p_rs);
    t_re   = T_W'(acc_re >>> TW_FRAC);
    t_im   = T_W'(acc_im >>> TW_FRAC);
    a_re_x = T_W'(are_q);
    a_im_x = T_W'(aim_q);
    sum_re = a_re_x + t_re;
    sum_im = a_im_x + t_im;
    dif_re = a_re_x - t_re;
    dif_im = a_im_x - t_im;
    new_are = DATA_W'(sum_re >>> 1);
    new_aim = DATA_W'(sum_im >>> 1);
    new_bre = DATA_W'(dif_re >>> 1);
    new_bim = DATA_W'(dif_im >>> 1);

    // max(|re|,|im|) + min(|re|,|im|)/2; real part is latched, imaginary arrives on data_in
    ext_re  = {are_q[DATA_W-1], are_q};
    ext_im  = {bus.data_in[DATA_W-1], bus.data_in};
    abs_re  = ext_re[DATA_W] ? -ext_re : ext_re;
    abs_im  = ext_im[DATA_W] ? -ext_im : ext_im;
    mag_mx  = (abs_re >= abs_im) ? abs_re : abs_im;
    mag_mn  = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_sum = MAG_W'(mag_mx) + MAG_W'(mag_mn >> 1);
    mag_val = DATA_W'((mag_sum > MAG_MAX) ? MAG_MAX : mag_sum);
  end

  // Sequencer: next state, next memory command and operand capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    dout_d  = dout_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    ph_d    = ph_q;
    are_d   = are_q;
    aim_d   = aim_q;
    bre_d   = bre_q;
    bim_d   = bim_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        addr_d = '0;
        if (bus.do_fft && !done_q) begin
          state_d = CLR_IM;
          cnt_d   = '0;
          stg_d   = '0;
          ph_d    = '0;
        end
      end

      CLR_IM: begin
        addr_d = {1'b1, cnt_q};
        we_d   = 1'b1;
        dout_d = '0;
        if (cnt_q == CNT_LAST) begin
          state_d = BITREV;
          cnt_d   = '0;
          ph_d    = '0;
        end else begin
          cnt_d = cnt_q + N_LOG2'(1);
        end
      end

      // Swap real words i and rev(i) once per pair: read, read, write, write.
      BITREV: begin
        ph_d = ph_q + 4'd1;
        unique case (ph_q)
          4'd0: begin
            if (cnt_q < cnt_rev) addr_d = {1'b0, cnt_q};
            else                 ph_d   = 4'd5;
          end
          4'd1: addr_d = {1'b0, cnt_rev};
          4'd2: are_d  = bus.data_in;
          4'd3: begin
            addr_d = {1'b0, cnt_q};
            we_d   = 1'b1;
            dout_d = bus.data_in;
          end
          4'd4: begin
            addr_d = {1'b0, cnt_rev};
            we_d   = 1'b1;
            dout_d = are_q;
          end
          default: ;
        endcase
        if (ph_d == 4'd5) begin
          ph_d = '0;
          if (cnt_q == CNT_LAST) begin
            state_d = BFLY;
            cnt_d   = '0;
            stg_d   = '0;
          end else begin
            cnt_d = cnt_q + N_LOG2'(1);
          end
        end
      end

      // Four pipelined reads, two idle capture cycles, four write-backs.
      BFLY: begin
        ph_d = ph_q + 4'd1;
        unique case (ph_q)
          4'd0: addr_d = {1'b0, idx_a};
          4'd1: addr_d = {1'b1, idx_a};
          4'd2: begin
            addr_d = {1'b0, idx_b};
            are_d  = bus.data_in;
          end
          4'd3: begin
            addr_d = {1'b1, idx_b};
            aim_d  = bus.data_in;
          end
          4'd4: bre_d = bus.data_in;
          4'd5: bim_d = bus.data_in;
          4'd6: begin
            addr_d = {1'b0, idx_a};
            we_d   = 1'b1;
            dout_d = new_are;
          end
          4'd7: begin
            addr_d = {1'b1, idx_a};
            we_d   = 1'b1;
            dout_d = new_aim;
          end
          4'd8: begin
            addr_d = {1'b0, idx_b};
            we_d   = 1'b1;
            dout_d = new_bre;
          end
          default: begin
            addr_d = {1'b1, idx_b};
            we_d   = 1'b1;
            dout_d = new_bim;
            ph_d   = '0;
            if (cnt_q == HALF_LAST) begin
              cnt_d = '0;
              if (stg_q == STG_LAST) state_d = MAG;
              else                   stg_d   = stg_q + STG_W'(1);
            end else begin
              cnt_d = cnt_q + N_LOG2'(1);
            end
          end
        endcase
      end

      // One extra cycle after the last write so the write never overlaps DONE.
      MAG: begin
        ph_d = ph_q + 4'd1;
        unique case (ph_q)
          4'd0: addr_d = {1'b0, cnt_q};
          4'd1: addr_d = {1'b1, cnt_q};
          4'd2: are_d  = bus.data_in;
          4'd3: begin
            addr_d = {1'b0, cnt_q};
            we_d   = 1'b1;
            dout_d = mag_val;
            if (cnt_q == HALF_LAST) begin
              ph_d = 4'd4;
            end else begin
              cnt_d = cnt_q + N_LOG2'(1);
              ph_d  = '0;
            end
          end
          default: begin
            addr_d  = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        endcase
      end

      DONE: begin
        done_d = 1'b1;
        if (!bus.do_fft) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Dropping the run request mid-transform abandons it immediately.
    if (!bus.do_fft && state_q != IDLE && state_q != DONE) begin
      state_d = IDLE;
      addr_d  = '0;
      we_d    = 1'b0;
      dout_d  = '0;
      done_d  = 1'b0;
      ph_d    = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      stg_q   <= '0;
      ph_q    <= '0;
      are_q   <= '0;
      aim_q   <= '0;
      bre_q   <= '0;
      bim_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      ph_q    <= ph_d;
      are_q   <= are_d;
      aim_q   <= aim_d;
      bre_q   <= bre_d;
      bim_q   <= bim_d;
    end
  end

  assign bus.addr          = addr_q;
  assign bus.write_enable  = we_q;
  assign bus.data_out_wire = dout_q;
  assign bus.fft_done      = done_q;

endmodule

// File: tb/tb_fft_engine.sv
// tb/tb_fft_engine.sv - scoreboard bench for fft_engine on a 128-point transform
module tb_fft_engine;
  localparam int N_LOG2  = 7;
  localparam int DATA_W  = 10;
  localparam int ADDR_W  = N_LOG2 + 1;
  localparam int TW_FRAC = 8;
  localparam int N       = 1 << N_LOG2;
  localparam int HALF    = N / 2;
  localparam int LAT_MAX = 12 * HALF * N_LOG2 + 8 * N;
  localparam int TIMEOUT = LAT_MAX + 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fft_engine #(
    .N_LOG2 (N_LOG2),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TW_FRAC(TW_FRAC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Single-port memory, 1-cycle read latency.
  logic [DATA_W-1:0] mem [2*N];
  always @(posedge clk) begin
    if (bus.write_enable) mem[bus.addr] <= bus.data_out_wire;
    bus.data_in <= mem[bus.addr];
  end

  int n_checks = 0;
  int n_pass = 0;
  int run_id = 0;
  int proto_bad = 0;
  logic done_prev = 1'b0;

  typedef struct {
    int    run;
    string name;
    int    a0;
    int    a1;
    int    lo;
    int    hi;
  } exp_t;
  exp_t sb[$];

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int sval(input int a);
    logic [ADDR_W-1:0] ai;
    ai = ADDR_W'(a);
    return int'($signed(mem[ai]));
  endfunction

  task automatic check_span(input exp_t e);
    int  bad;
    bit  ok;
    ok  = 1'b1;
    bad = sval(e.a0);
    for (int a = e.a0; a <= e.a1; a++) begin
      int v;
      v = sval(a);
      if (ok && (v < e.lo || v > e.hi)) begin
        ok  = 1'b0;
        bad = v;
      end
    end
    check_rng(e.name, bad, e.lo, e.hi);
  endtask

  task automatic expect_span(input string name, input int a0, input int a1, input int lo, input int hi);
    exp_t e;
    e.run = run_id; e.name = name; e.a0 = a0; e.a1 = a1; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Monitor: on each rising fft_done, pop and check the expectations of the current run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.fft_done && !done_prev) begin
        while (sb.size() > 0 && sb[0].run <= run_id) begin
          e = sb.pop_front();
          if (e.run < run_id) check_rng({"stale_", e.name}, e.run, run_id, run_id);
          else check_span(e);
        end
      end
      done_prev = bus.fft_done;
    end
  end

  always @(negedge clk) if (bus.fft_done && bus.write_enable) proto_bad++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind: 0 = DC 100, 1 = cosine at bin 8, 2 = zero, 3 = impulse 511
  task automatic load(input int kind);
    int cos16[16];
    cos16 = '{400, 370, 283, 153, 0, -153, -283, -370, -400, -370, -283, -153, 0, 153, 283, 370};
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       mem[i] = DATA_W'(100);
        1:       mem[i] = DATA_W'(cos16[i % 16]);
        3:       mem[i] = (i == 0) ? DATA_W'(511) : '0;
        default: mem[i] = '0;
      endcase
      mem[N + i] = DATA_W'(10'h2AA);
    end
  endtask

  task automatic run_fft();
    int cyc;
    @(negedge clk);
    bus.do_fft = 1'b1;
    cyc = 0;
    while (!bus.fft_done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check_rng("latency", cyc, 1, LAT_MAX);
    repeat (2) @(negedge clk);
  endtask

  task automatic release_fft();
    bus.do_fft = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_dc();
    expect_span("dc_bin0", 0, 0, 96, 100);
    expect_span("dc_bins", 1, HALF - 1, 0, 2);
  endtask

  task automatic expect_cos();
    expect_span("cos_bin8", 8, 8, 195, 205);
    expect_span("cos_low", 0, 7, 0, 8);
    expect_span("cos_high", 9, HALF - 1, 0, 8);
  endtask

  initial begin
    bit hold_ok, nowr_ok;
    bus.do_fft = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rng("rst_addr", int'(bus.addr), 0, 0);
    check_rng("rst_we", int'(bus.write_enable), 0, 0);
    check_rng("rst_dout", int'(bus.data_out_wire), 0, 0);
    check_rng("rst_done", int'(bus.fft_done), 0, 0);
    rst_n = 1'b1;

    // DC
    load(0); run_id++; expect_dc(); run_fft(); release_fft();

    // Cosine, then hold do_fft after done
    load(1); run_id++; expect_cos(); run_fft();
    hold_ok = 1'b1; nowr_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!bus.fft_done) hold_ok = 1'b0;
      if (bus.write_enable) nowr_ok = 1'b0;
    end
    check_rng("hold_done", int'(hold_ok), 1, 1);
    check_rng("hold_nowrite", int'(nowr_ok), 1, 1);
    bus.do_fft = 1'b0;
    @(posedge clk); #1;
    check_rng("done_clear", int'(bus.fft_done), 0, 0);
    repeat (3) @(negedge clk);

    // Cosine again
    load(1); run_id++; expect_cos(); run_fft(); release_fft();

    // Zero input, imaginary half preloaded with garbage
    load(2); run_id++;
    expect_span("zero_bins", 0, HALF - 1, 0, 0);
    expect_span("zero_imag", N, 2 * N - 1, 0, 0);
    run_fft(); release_fft();

    // Reset during the butterfly stages
    load(0);
    @(negedge clk); bus.do_fft = 1'b1;
    repeat (1500) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_rng("rst_mid_we", int'(bus.write_enable), 0, 0);
    check_rng("rst_mid_done", int'(bus.fft_done), 0, 0);
    check_rng("rst_mid_addr", int'(bus.addr), 0, 0);
    @(negedge clk); bus.do_fft = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Abort by dropping do_fft mid-run
    load(0);
    @(negedge clk); bus.do_fft = 1'b1;
    repeat (800) @(negedge clk);
    bus.do_fft = 1'b0;
    @(posedge clk); #1;
    check_rng("abort_we", int'(bus.write_enable), 0, 0);
    check_rng("abort_addr", int'(bus.addr), 0, 0);
    repeat (3) @(negedge clk);
    check_rng("abort_done", int'(bus.fft_done), 0, 0);

    // DC after reset and abort
    load(0); run_id++; expect_dc(); run_fft(); release_fft();

    // Impulse 511: 511 halved over 7 stages gives 3 in every bin
    load(3); run_id++;
    expect_span("imp_bins", 0, HALF - 1, 2, 4);
    run_fft(); release_fft();

    repeat (5) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_rng({"unchecked_", e.name}, 0, 1, 1);
    end
    check_rng("write_in_done", proto_bad, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
